// File: rtl/missile_pkg.sv
// Shared definitions for the launch sequencer and the command interpreter.
package missile_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    LAUNCH   = 3'd2,
    FLIGHT   = 3'd3,
    COOLDOWN = 3'd4,
    OUT      = 3'd5
  } state_e;

  localparam int unsigned VEL_MAX                = 99999;
  localparam int unsigned ANGLE_MAX              = 90;
  localparam int unsigned VEL_DEFAULT            = 60;
  localparam int unsigned ANGLE_DEFAULT          = 70;
  localparam int unsigned SHOTS_DEFAULT          = 10;
  localparam int unsigned FLIGHT_TIMEOUT_DEFAULT = 500_000_000;
  localparam int unsigned COOLDOWN_DEFAULT       = 25_000_000;

  // Bits needed to hold (max(a, b) - 1), never less than one.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/launch_timer.sv
// Loadable down-counter shared by the flight timeout and the cooldown wait.
// expired_o is high while the count sits at zero.
module launch_timer #(
  parameter int unsigned W = 32
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] count_q, count_d;

  // Clear beats load; otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/launch_controller.sv
// One-shot-at-a-time launch sequencer between the command interpreter and
// the physics engine.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | waiting for fire, pending operands may change
//   ARM      | one cycle; launch registers already hold the shot
//   LAUNCH   | launch_start asserted until the engine acks
//   FLIGHT   | waiting for flight_done or the timeout
//   COOLDOWN | fixed dead time before the next shot
//   OUT      | no shots left; only a game reset leaves
module launch_controller
  import missile_pkg::*;
#(
  parameter int unsigned SHOTS           = SHOTS_DEFAULT,
  parameter int unsigned FLIGHT_TIMEOUT  = FLIGHT_TIMEOUT_DEFAULT,
  parameter int unsigned COOLDOWN_CYCLES = COOLDOWN_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        set_v,
  input  logic        set_a,
  input  logic        fire,
  input  logic        game_reset,
  input  logic [31:0] velocity_in,
  input  logic [31:0] angle_in,
  input  logic        launch_ack,
  input  logic        flight_done,
  input  logic        hit,
  output logic        launch_start,
  output logic [31:0] launch_velocity,
  output logic [31:0] launch_angle,
  output logic        busy,
  output logic [7:0]  shots_left,
  output logic [15:0] score,
  output logic        cmd_error,
  output logic        timeout
);

  localparam int unsigned    TW          = timer_width(FLIGHT_TIMEOUT, COOLDOWN_CYCLES);
  localparam logic [TW-1:0]  FLIGHT_LOAD = TW'(FLIGHT_TIMEOUT - 1);
  localparam logic [TW-1:0]  COOL_LOAD   = TW'(COOLDOWN_CYCLES - 1);

  state_e        state_q, state_d;
  logic [31:0]   pend_v_q, pend_v_d;
  logic [31:0]   pend_a_q, pend_a_d;
  logic [31:0]   launch_v_q, launch_v_d;
  logic [31:0]   launch_a_q, launch_a_d;
  logic          launch_start_q, launch_start_d;
  logic          busy_q, busy_d;
  logic [7:0]    shots_q, shots_d;
  logic [15:0]   score_q, score_d;
  logic          cmd_err_q, cmd_err_d;
  logic          timeout_q, timeout_d;

  logic          timer_clear, timer_load, timer_expired;
  logic [TW-1:0] timer_val;

  logic v_ok, a_ok, fire_ok, acked, flight_timed_out;

  assign v_ok             = (velocity_in != 32'd0) && (velocity_in <= 32'(VEL_MAX));
  assign a_ok             = (angle_in <= 32'(ANGLE_MAX));
  assign fire_ok          = fire && (state_q == IDLE) && (shots_q != 8'd0);
  assign acked            = (state_q == LAUNCH) && launch_ack;
  // A landing reported on the expiry cycle takes precedence over the timeout.
  assign flight_timed_out = (state_q == FLIGHT) && timer_expired && !flight_done;

  launch_timer #(.W(TW)) u_timer (
    .clock_i    (clock),
    .reset_i    (reset),
    .clear_i    (timer_clear),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .expired_o  (timer_expired)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a game reset overrides every transition.
  always_comb begin
    state_d = state_q;
    if (game_reset) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (fire_ok) state_d = ARM;
        ARM:      state_d = LAUNCH;
        LAUNCH:   if (launch_ack) state_d = FLIGHT;
        FLIGHT:   if (flight_done || timer_expired) state_d = COOLDOWN;
        COOLDOWN: if (timer_expired) state_d = (shots_q == 8'd0) ? OUT : IDLE;
        OUT:      state_d = OUT;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs, pending operands and timer control.
  always_comb begin
    pend_v_d    = pend_v_q;
    pend_a_d    = pend_a_q;
    launch_v_d  = launch_v_q;
    launch_a_d  = launch_a_q;
    shots_d     = shots_q;
    score_d     = score_q;
    cmd_err_d   = 1'b0;
    timeout_d   = 1'b0;
    timer_clear = 1'b0;
    timer_load  = 1'b0;
    timer_val   = '0;

    if (game_reset) begin
      pend_v_d    = 32'(VEL_DEFAULT);
      pend_a_d    = 32'(ANGLE_DEFAULT);
      shots_d     = 8'(SHOTS);
      score_d     = 16'd0;
      timer_clear = 1'b1;
    end else begin
      if (set_v && v_ok) pend_v_d = velocity_in;
      if (set_a && a_ok) pend_a_d = angle_in;
      // Latch the pre-update pending values so a same-cycle set only
      // affects the following shot.
      if (fire_ok) begin
        launch_v_d = pend_v_q;
        launch_a_d = pend_a_q;
      end
      cmd_err_d = (set_v && !v_ok) || (set_a && !a_ok) || (fire && !fire_ok);
      if (acked) begin
        shots_d    = shots_q - 8'd1;
        timer_load = 1'b1;
        timer_val  = FLIGHT_LOAD;
      end
      if ((state_q == FLIGHT) && flight_done && hit && (score_q != 16'hFFFF)) begin
        score_d = score_q + 16'd1;
      end
      timeout_d = flight_timed_out;
      if ((state_q == FLIGHT) && (state_d == COOLDOWN)) begin
        timer_load = 1'b1;
        timer_val  = COOL_LOAD;
      end
    end

    launch_start_d = (state_d == LAUNCH);
    busy_d         = (state_d != IDLE) && (state_d != OUT);
  end

  // Output and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_v_q       <= 32'(VEL_DEFAULT);
      pend_a_q       <= 32'(ANGLE_DEFAULT);
      launch_v_q     <= 32'(VEL_DEFAULT);
      launch_a_q     <= 32'(ANGLE_DEFAULT);
      launch_start_q <= 1'b0;
      busy_q         <= 1'b0;
      shots_q        <= 8'(SHOTS);
      score_q        <= 16'd0;
      cmd_err_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      pend_v_q       <= pend_v_d;
      pend_a_q       <= pend_a_d;
      launch_v_q     <= launch_v_d;
      launch_a_q     <= launch_a_d;
      launch_start_q <= launch_start_d;
      busy_q         <= busy_d;
      shots_q        <= shots_d;
      score_q        <= score_d;
      cmd_err_q      <= cmd_err_d;
      timeout_q      <= timeout_d;
    end
  end

  assign launch_start    = launch_start_q;
  assign launch_velocity = launch_v_q;
  assign launch_angle    = launch_a_q;
  assign busy            = busy_q;
  assign shots_left      = shots_q;
  assign score           = score_q;
  assign cmd_error       = cmd_err_q;
  assign timeout         = timeout_q;

endmodule

// File: tb/tb_launch_controller.sv
// Bench for launch_controller with a small game: 2 shots, 20-cycle flight
// timeout, 5-cycle cooldown. Expected launch operands are queued when fire
// is driven and checked when launch_start rises.
module tb_launch_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        set_v = 1'b0, set_a = 1'b0, fire = 1'b0, game_reset = 1'b0;
  logic [31:0] velocity_in = '0, angle_in = '0;
  logic        launch_ack = 1'b0, flight_done = 1'b0, hit = 1'b0;
  logic        launch_start, busy, cmd_error, timeout;
  logic [31:0] launch_velocity, launch_angle;
  logic [7:0]  shots_left;
  logic [15:0] score;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] v;
    logic [31:0] a;
  } launch_t;
  launch_t exp_q[$];
  logic    ls_prev = 1'b0;

  launch_controller #(
    .SHOTS(2), .FLIGHT_TIMEOUT(20), .COOLDOWN_CYCLES(5)
  ) dut (
    .clock(clock), .reset(reset), .set_v(set_v), .set_a(set_a), .fire(fire),
    .game_reset(game_reset), .velocity_in(velocity_in), .angle_in(angle_in),
    .launch_ack(launch_ack), .flight_done(flight_done), .hit(hit),
    .launch_start(launch_start), .launch_velocity(launch_velocity),
    .launch_angle(launch_angle), .busy(busy), .shots_left(shots_left),
    .score(score), .cmd_error(cmd_error), .timeout(timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every launch_start rising edge consumes one expected shot.
  always @(negedge clock) begin
    if (launch_start && !ls_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL launch_unexpected: got v=%0d a=%0d, required no launch", launch_velocity, launch_angle);
      end else begin
        launch_t e;
        e = exp_q.pop_front();
        if (launch_velocity !== e.v || launch_angle !== e.a) begin
          failures++;
          $display("FAIL launch_operands: got v=%0d a=%0d, required v=%0d a=%0d",
                   launch_velocity, launch_angle, e.v, e.a);
        end
      end
    end
    ls_prev = launch_start;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    checks++; if (launch_start !== 1'b0) begin failures++; $display("FAIL rst_launch_start got=%0d req=0", launch_start); end
    checks++; if (launch_velocity !== 32'd60) begin failures++; $display("FAIL rst_velocity got=%0d req=60", launch_velocity); end
    checks++; if (launch_angle !== 32'd70) begin failures++; $display("FAIL rst_angle got=%0d req=70", launch_angle); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0d req=0", busy); end
    checks++; if (shots_left !== 8'd2) begin failures++; $display("FAIL rst_shots got=%0d req=2", shots_left); end
    checks++; if (score !== 16'd0) begin failures++; $display("FAIL rst_score got=%0d req=0", score); end
    checks++; if (cmd_error !== 1'b0) begin failures++; $display("FAIL rst_cmd_error got=%0d req=0", cmd_error); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL rst_timeout got=%0d req=0", timeout); end
  endtask

  // Ack held from IDLE onward; only the one seen in LAUNCH counts.
  task automatic test_first_shot();
    int n;
    exp_q.push_back('{32'd60, 32'd70});
    fire = 1'b1; launch_ack = 1'b1;
    cyc();
    fire = 1'b0;
    checks++; if (busy !== 1'b1 || launch_start !== 1'b0) begin failures++; $display("FAIL arm_state busy=%0d ls=%0d req busy=1 ls=0", busy, launch_start); end
    cyc();
    checks++; if (launch_start !== 1'b1 || shots_left !== 8'd2) begin failures++; $display("FAIL launch_cycle ls=%0d shots=%0d req ls=1 shots=2", launch_start, shots_left); end
    cyc();
    launch_ack = 1'b0;
    checks++; if (launch_start !== 1'b0) begin failures++; $display("FAIL ls_one_cycle got=%0d req=0", launch_start); end
    checks++; if (shots_left !== 8'd1) begin failures++; $display("FAIL shots_after_ack got=%0d req=1", shots_left); end
    flight_done = 1'b1; hit = 1'b0;
    cyc();
    flight_done = 1'b0;
    checks++; if (score !== 16'd0 || busy !== 1'b1) begin failures++; $display("FAIL miss_score score=%0d busy=%0d req score=0 busy=1", score, busy); end
    n = 0;
    while (busy && n < 50) begin cyc(); n++; end
    checks++; if (n != 5) begin failures++; $display("FAIL cooldown_len got=%0d req=5", n); end
  endtask

  task automatic test_hit_and_out();
    int n;
    set_v = 1'b1; velocity_in = 32'd1234; set_a = 1'b1; angle_in = 32'd45;
    cyc();
    set_v = 1'b0; set_a = 1'b0;
    checks++; if (cmd_error !== 1'b0) begin failures++; $display("FAIL valid_set_err got=%0d req=0", cmd_error); end
    exp_q.push_back('{32'd1234, 32'd45});
    fire = 1'b1;
    cyc();
    fire = 1'b0;
    cyc();
    launch_ack = 1'b1;
    cyc();
    launch_ack = 1'b0;
    checks++; if (shots_left !== 8'd0) begin failures++; $display("FAIL shots_last got=%0d req=0", shots_left); end
    repeat (6) cyc();
    flight_done = 1'b1; hit = 1'b1;
    cyc();
    flight_done = 1'b0; hit = 1'b0;
    checks++; if (score !== 16'd1 || timeout !== 1'b0) begin failures++; $display("FAIL hit_score score=%0d to=%0d req score=1 to=0", score, timeout); end
    n = 0;
    while (busy && n < 50) begin cyc(); n++; end
    checks++; if (n != 5) begin failures++; $display("FAIL busy_after_done got=%0d req=5", n); end
    fire = 1'b1;
    cyc();
    fire = 1'b0;
    checks++; if (cmd_error !== 1'b1 || busy !== 1'b0 || launch_start !== 1'b0) begin failures++; $display("FAIL out_fire err=%0d busy=%0d ls=%0d req err=1 busy=0 ls=0", cmd_error, busy, launch_start); end
    cyc();
    checks++; if (cmd_error !== 1'b0) begin failures++; $display("FAIL err_pulse_width got=%0d req=0", cmd_error); end
  endtask

  task automatic test_game_reset();
    game_reset = 1'b1;
    cyc();
    game_reset = 1'b0;
    checks++; if (shots_left !== 8'd2 || score !== 16'd0 || busy !== 1'b0 || launch_start !== 1'b0) begin
      failures++; $display("FAIL game_reset shots=%0d score=%0d busy=%0d ls=%0d req 2/0/0/0", shots_left, score, busy, launch_start);
    end
  endtask

  task automatic test_bad_cmds_timeout();
    int c;
    int n;
    set_v = 1'b1; velocity_in = 32'd99999; set_a = 1'b1; angle_in = 32'd90;
    cyc();
    set_v = 1'b0; set_a = 1'b0;
    checks++; if (cmd_error !== 1'b0) begin failures++; $display("FAIL max_ok_err got=%0d req=0", cmd_error); end
    set_a = 1'b1; angle_in = 32'd91;
    cyc();
    set_a = 1'b0;
    checks++; if (cmd_error !== 1'b1) begin failures++; $display("FAIL angle91_err got=%0d req=1", cmd_error); end
    cyc();
    checks++; if (cmd_error !== 1'b0) begin failures++; $display("FAIL err_clear got=%0d req=0", cmd_error); end
    set_v = 1'b1; velocity_in = 32'd0;
    cyc();
    set_v = 1'b0;
    checks++; if (cmd_error !== 1'b1) begin failures++; $display("FAIL vel0_err got=%0d req=1", cmd_error); end
    set_v = 1'b1; velocity_in = 32'd100000; set_a = 1'b1; angle_in = 32'd200;
    cyc();
    set_v = 1'b0; set_a = 1'b0;
    checks++; if (cmd_error !== 1'b1) begin failures++; $display("FAIL dual_err got=%0d req=1", cmd_error); end
    cyc();
    checks++; if (cmd_error !== 1'b0) begin failures++; $display("FAIL dual_err_single got=%0d req=0", cmd_error); end
    exp_q.push_back('{32'd99999, 32'd90});
    fire = 1'b1;
    cyc();
    fire = 1'b0;
    cyc();
    cyc();
    cyc();
    checks++; if (launch_start !== 1'b1) begin failures++; $display("FAIL ls_hold got=%0d req=1", launch_start); end
    launch_ack = 1'b1;
    cyc();
    launch_ack = 1'b0;
    c = 0;
    fire = 1'b1; set_v = 1'b1; velocity_in = 32'd777;
    cyc(); c++;
    fire = 1'b0; set_v = 1'b0;
    checks++; if (cmd_error !== 1'b1 || launch_start !== 1'b0 || launch_velocity !== 32'd99999) begin
      failures++; $display("FAIL flight_fire err=%0d ls=%0d v=%0d req err=1 ls=0 v=99999", cmd_error, launch_start, launch_velocity);
    end
    while (c < 19) begin
      cyc(); c++;
      checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL early_timeout cycle=%0d got=1 req=0", c); end
    end
    cyc();
    checks++; if (timeout !== 1'b1 || score !== 16'd0 || busy !== 1'b1) begin
      failures++; $display("FAIL timeout_pulse to=%0d score=%0d busy=%0d req 1/0/1", timeout, score, busy);
    end
    n = 0;
    while (busy && n < 50) begin cyc(); n++; end
    checks++; if (n != 5 || timeout !== 1'b0 || shots_left !== 8'd1) begin
      failures++; $display("FAIL timeout_cooldown n=%0d to=%0d shots=%0d req 5/0/1", n, timeout, shots_left);
    end
  endtask

  task automatic test_same_cycle();
    int n;
    exp_q.push_back('{32'd60, 32'd70});
    set_v = 1'b1; velocity_in = 32'd500; fire = 1'b1;
    cyc();
    set_v = 1'b0; fire = 1'b0;
    cyc();
    checks++; if (launch_velocity !== 32'd60) begin failures++; $display("FAIL same_cycle_old got=%0d req=60", launch_velocity); end
    launch_ack = 1'b1;
    cyc();
    launch_ack = 1'b0; flight_done = 1'b1; hit = 1'b1;
    cyc();
    flight_done = 1'b0; hit = 1'b0;
    checks++; if (score !== 16'd1) begin failures++; $display("FAIL sc_score1 got=%0d req=1", score); end
    n = 0;
    while (busy && n < 50) begin cyc(); n++; end
    exp_q.push_back('{32'd500, 32'd70});
    fire = 1'b1;
    cyc();
    fire = 1'b0;
    cyc();
    launch_ack = 1'b1;
    cyc();
    launch_ack = 1'b0;
    repeat (19) cyc();
    flight_done = 1'b1; hit = 1'b1;
    cyc();
    flight_done = 1'b0; hit = 1'b0;
    checks++; if (timeout !== 1'b0 || score !== 16'd2) begin failures++; $display("FAIL done_beats_timeout to=%0d score=%0d req to=0 score=2", timeout, score); end
    n = 0;
    while (busy && n < 50) begin cyc(); n++; end
    checks++; if (n != 5 || shots_left !== 8'd0) begin failures++; $display("FAIL out_reached n=%0d shots=%0d req 5/0", n, shots_left); end
  endtask

  task automatic test_game_reset_mid_flight();
    int n;
    test_game_reset();
    exp_q.push_back('{32'd60, 32'd70});
    fire = 1'b1;
    cyc();
    fire = 1'b0;
    cyc();
    launch_ack = 1'b1;
    cyc();
    launch_ack = 1'b0; flight_done = 1'b1; hit = 1'b1;
    cyc();
    flight_done = 1'b0; hit = 1'b0;
    n = 0;
    while (busy && n < 50) begin cyc(); n++; end
    checks++; if (score !== 16'd1) begin failures++; $display("FAIL mid_pre_score got=%0d req=1", score); end
    exp_q.push_back('{32'd60, 32'd70});
    fire = 1'b1;
    cyc();
    fire = 1'b0;
    cyc();
    launch_ack = 1'b1;
    cyc();
    launch_ack = 1'b0;
    repeat (3) cyc();
    game_reset = 1'b1;
    cyc();
    game_reset = 1'b0;
    checks++; if (busy !== 1'b0 || shots_left !== 8'd2 || score !== 16'd0 || launch_start !== 1'b0) begin
      failures++; $display("FAIL mid_reset busy=%0d shots=%0d score=%0d ls=%0d req 0/2/0/0", busy, shots_left, score, launch_start);
    end
    flight_done = 1'b1; hit = 1'b1;
    cyc();
    flight_done = 1'b0; hit = 1'b0;
    checks++; if (score !== 16'd0 || busy !== 1'b0) begin failures++; $display("FAIL late_done score=%0d busy=%0d req 0/0", score, busy); end
    repeat (25) cyc();
    checks++; if (timeout !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abandoned_flight to=%0d busy=%0d req 0/0", timeout, busy); end
  endtask

  initial begin
    test_reset();
    test_first_shot();
    test_hit_and_out();
    test_game_reset();
    test_bad_cmds_timeout();
    test_game_reset();
    test_same_cycle();
    test_game_reset_mid_flight();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL launches_missing got=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
